// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART packet loader.
//   state_t : framing FSM states
//   err_t   : error cause reported on error_code
//   DEFAULT_SYNC_BYTE : default packet start marker
//   bytes_per_word()  : bytes needed to fill one memory word
package uart_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        PAYLOAD,
        CHECK
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_CSUM,
        ERR_SIZE,
        ERR_TIMEOUT
    } err_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic int unsigned bytes_per_word(input int unsigned width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_packet_loader_packer.sv
// Little-endian byte-to-word packer.
//   clk, rstN     : clock, synchronous active-low reset
//   byte_valid_i  : byte_in_i is valid this cycle
//   byte_in_i     : incoming byte, placed at bits [8k+7:8k] for byte index k
//   clear_i       : restart at byte index 0 (partial word discarded)
//   last_byte_o   : the next accepted byte completes a word
//   word_valid_o  : one-cycle pulse, the cycle after the completing byte
//   word_out_o    : assembled word, bits above WORD_WIDTH dropped
module byte_word_packer
    import uart_loader_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 60
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_in_i,
    input  logic                  clear_i,
    output logic                  last_byte_o,
    output logic                  word_valid_o,
    output logic [WORD_WIDTH-1:0] word_out_o
);

    localparam int unsigned BPW   = bytes_per_word(WORD_WIDTH);
    localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BPW*8-1:0]      asm_q, asm_d;
    logic                  word_valid_q, word_valid_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;

    assign last_byte_o  = (idx_q == LAST_IDX);
    assign word_valid_o = word_valid_q;
    assign word_out_o   = word_q;

    always_comb begin
        idx_d        = idx_q;
        asm_d        = asm_q;
        word_valid_d = 1'b0;
        word_d       = word_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (byte_valid_i) begin
            asm_d[8*32'(idx_q) +: 8] = byte_in_i;
            if (idx_q == LAST_IDX) begin
                idx_d        = '0;
                word_valid_d = 1'b1;
                word_d       = asm_d[WORD_WIDTH-1:0];
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            idx_q        <= '0;
            asm_q        <= '0;
            word_valid_q <= 1'b0;
            word_q       <= '0;
        end else begin
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            word_valid_q <= word_valid_d;
            word_q       <= word_d;
        end
    end

endmodule

// File: rtl/uart_packet_loader.sv
// Receive-side framing stage: parses SYNC, 16-bit word count (LE), payload,
// checksum from a UART byte stream and writes payload words to RAM.
//   clk, rstN     : clock, synchronous active-low reset
//   enable        : loading permitted; dropping it mid-packet aborts silently
//   rx_byte_valid : one-cycle strobe for rx_byte
//   rx_byte       : received byte
//   mem_wr_en     : one-cycle write strobe; mem_addr / mem_data valid with it
//   busy          : packet in progress
//   load_done     : one-cycle pulse, packet good
//   load_error    : one-cycle pulse, packet bad; cause on error_code
//   error_code    : held until the next accepted sync
//   words_written : words written in the current or last packet
module uart_packet_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned WORD_WIDTH     = 60,
    parameter int unsigned MEM_DEPTH      = 4096,
    parameter int unsigned ADDR_WIDTH     = $clog2(MEM_DEPTH),
    parameter int unsigned START_ADDR     = 0,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  enable,
    input  logic                  rx_byte_valid,
    input  logic [7:0]            rx_byte,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_error,
    output logic [1:0]            error_code,
    output logic [15:0]           words_written
);

    localparam int unsigned CAPACITY = MEM_DEPTH - START_ADDR;
    localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        csum_q, csum_d;
    logic [15:0]       words_seen_q, words_seen_d;
    logic [15:0]       words_q, words_d;
    err_t              err_q, err_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic pack_valid, pack_clear, pack_last, pack_word_valid;
    logic [WORD_WIDTH-1:0] pack_word;

    byte_word_packer #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_packer (
        .clk         (clk),
        .rstN        (rstN),
        .byte_valid_i(pack_valid),
        .byte_in_i   (rx_byte),
        .clear_i     (pack_clear),
        .last_byte_o (pack_last),
        .word_valid_o(pack_word_valid),
        .word_out_o  (pack_word)
    );

    assign mem_wr_en     = pack_word_valid;
    assign mem_data      = pack_word;
    assign mem_addr      = ADDR_WIDTH'(START_ADDR + 32'(words_q));
    assign busy          = (state_q != IDLE);
    assign load_done     = done_q;
    assign load_error    = error_q;
    assign error_code    = err_q;
    assign words_written = words_q;

    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        csum_d       = csum_q;
        words_seen_d = words_seen_q;
        words_d      = words_q;
        err_d        = err_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        tmo_d        = '0;
        pack_valid   = 1'b0;
        pack_clear   = 1'b0;

        if (pack_word_valid) words_d = words_q + 16'd1;
        if (state_q != IDLE) tmo_d = rx_byte_valid ? '0 : tmo_q + TMO_W'(1);

        case (state_q)
            IDLE: begin
                if (rx_byte_valid && enable && rx_byte == SYNC_BYTE) begin
                    err_d        = ERR_NONE;
                    words_d      = '0;
                    words_seen_d = '0;
                    csum_d       = '0;
                    pack_clear   = 1'b1;
                    state_d      = LEN_LO;
                end
            end
            LEN_LO: begin
                if (rx_byte_valid) begin
                    len_lo_d = rx_byte;
                    csum_d   = csum_q + rx_byte;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (rx_byte_valid) begin
                    len_d  = {rx_byte, len_lo_q};
                    csum_d = csum_q + rx_byte;
                    if (32'({rx_byte, len_lo_q}) > CAPACITY) begin
                        error_d = 1'b1;
                        err_d   = ERR_SIZE;
                        state_d = IDLE;
                    end else if ({rx_byte, len_lo_q} == 16'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_byte_valid) begin
                    csum_d     = csum_q + rx_byte;
                    pack_valid = 1'b1;
                    // Leave on the completing byte itself so a checksum byte
                    // arriving during the final write is taken as the checksum.
                    if (pack_last) begin
                        words_seen_d = words_seen_q + 16'd1;
                        if (words_seen_q + 16'd1 == len_q) state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (rx_byte_valid) begin
                    if (rx_byte == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                        err_d   = ERR_CSUM;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && !rx_byte_valid && tmo_q == TMO_LAST) begin
            error_d = 1'b1;
            err_d   = ERR_TIMEOUT;
            state_d = IDLE;
        end

        if (state_q != IDLE && !enable) begin
            state_d    = IDLE;
            done_d     = 1'b0;
            error_d    = 1'b0;
            err_d      = err_q;
            pack_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q      <= IDLE;
            len_lo_q     <= '0;
            len_q        <= '0;
            csum_q       <= '0;
            words_seen_q <= '0;
            words_q      <= '0;
            err_q        <= ERR_NONE;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            csum_q       <= csum_d;
            words_seen_q <= words_seen_d;
            words_q      <= words_d;
            err_q        <= err_d;
            done_q       <= done_d;
            error_q      <= error_d;
            tmo_q        <= tmo_d;
        end
    end

endmodule

// File: tb/tb_uart_packet_loader.sv
module tb_uart_packet_loader;

    localparam int unsigned WW  = 60;
    localparam int unsigned AW  = 12;
    localparam int unsigned TMO = 100;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          enable = 1'b0;
    logic          rx_byte_valid = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_data;
    logic          busy;
    logic          load_done;
    logic          load_error;
    logic [1:0]    error_code;
    logic [15:0]   words_written;

    uart_packet_loader #(
        .WORD_WIDTH    (WW),
        .MEM_DEPTH     (4096),
        .START_ADDR    (0),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rstN         (rstN),
        .enable       (enable),
        .rx_byte_valid(rx_byte_valid),
        .rx_byte      (rx_byte),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .busy         (busy),
        .load_done    (load_done),
        .load_error   (load_error),
        .error_code   (error_code),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    // kind: 0 = memory write, 1 = load_done, 2 = load_error
    typedef struct {
        int          kind;
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] code;
        logic [63:0] words;
    } exp_t;

    typedef logic [7:0] bq_t[$];

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int kind, input logic [63:0] addr, input logic [63:0] data,
                            input logic [63:0] code, input logic [63:0] words);
        exp_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.code = code; e.words = words;
        sb.push_back(e);
    endtask

    // ---------------- monitor ----------------
    task automatic observe(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d, required none", kind);
            return;
        end
        e = sb.pop_front();
        chk("event_kind", 64'(kind), 64'(e.kind));
        if (kind == 0) begin
            chk("mem_addr", 64'(mem_addr), e.addr);
            chk("mem_data", 64'(mem_data), e.data);
        end else begin
            chk("error_code", 64'(error_code), e.code);
            chk("words_written", 64'(words_written), e.words);
        end
    endtask

    always @(negedge clk) begin
        if (mem_wr_en)  observe(0);
        if (load_done)  observe(1);
        if (load_error) observe(2);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        rx_byte       = b;
        rx_byte_valid = 1'b1;
        @(posedge clk); #1;
        rx_byte_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    // Reference model: expected writes are the payload grouped 8 bytes per
    // word, little-endian, reduced mod 2^60; checksum is the byte sum mod 256
    // of length and payload. csum_force: -1 correct, -2 random wrong, else value.
    task automatic send_packet(input bq_t pl, input int unsigned n, input int csum_force,
                               input int unsigned max_gap);
        logic [7:0]  sum;
        logic [7:0]  cb;
        logic [63:0] w;
        sum = 8'(n) + 8'(n >> 8);
        foreach (pl[i]) sum = sum + pl[i];
        for (int unsigned wi = 0; wi < n; wi++) begin
            w = 64'd0;
            for (int unsigned k = 0; k < 8; k++) w = w + (64'(pl[8*wi+k]) << (8*k));
            w = w % (64'd1 << WW);
            push_exp(0, 64'(wi), w, 0, 0);
        end
        if (csum_force == -1)      cb = sum;
        else if (csum_force == -2) cb = sum + 8'($urandom_range(1, 255));
        else                       cb = 8'(csum_force);
        if (cb == sum) push_exp(1, 0, 0, 0, 64'(n));
        else           push_exp(2, 0, 0, 1, 64'(n));

        send_byte(8'hA5, $urandom_range(0, max_gap));
        send_byte(8'(n), $urandom_range(0, max_gap));
        send_byte(8'(n >> 8), $urandom_range(0, max_gap));
        foreach (pl[i]) send_byte(pl[i], $urandom_range(0, max_gap));
        send_byte(cb, 0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && sb.size() != 0; i++) begin @(posedge clk); #1; end
        repeat (3) begin @(posedge clk); #1; end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_mem_wr_en", 64'(mem_wr_en), 0);
        chk("rst_mem_addr", 64'(mem_addr), 0);
        chk("rst_mem_data", 64'(mem_data), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_load_done", 64'(load_done), 0);
        chk("rst_load_error", 64'(load_error), 0);
        chk("rst_error_code", 64'(error_code), 0);
        chk("rst_words_written", 64'(words_written), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bq_t         pl;
        bq_t         rp;
        int unsigned n;
        int unsigned cyc;
        logic [7:0]  nb;

        rstN = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check_reset_outputs();
        rstN   = 1'b1;
        enable = 1'b1;
        @(posedge clk); #1;

        // Good packet, back-to-back bytes
        pl = {};
        for (int i = 1; i <= 16; i++) pl.push_back(8'(i));
        send_packet(pl, 2, -1, 0);
        drain("good_drain");
        chk("good_error_code", 64'(error_code), 0);
        chk("good_words", 64'(words_written), 2);

        // Bad checksum: final byte 00
        send_packet(pl, 2, 0, 1);
        drain("csum_drain");
        chk("csum_error_code", 64'(error_code), 1);

        // Oversize: N = 4097
        push_exp(2, 0, 0, 2, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h01, 1);
        send_byte(8'h10, 0);
        drain("size_drain");
        chk("size_busy", 64'(busy), 0);

        // Timeout after three payload bytes
        push_exp(2, 0, 0, 3, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 2);
        send_byte(8'h33, 0);
        chk("tmo_busy_during", 64'(busy), 1);
        cyc = 0;
        while (!load_error && cyc < 3 * TMO) begin @(posedge clk); #1; cyc++; end
        chk("tmo_window", 64'(cyc >= TMO - 1 && cyc <= TMO + 1), 1);
        @(posedge clk); #1;
        chk("tmo_busy_after", 64'(busy), 0);
        chk("tmo_error_code", 64'(error_code), 3);
        drain("tmo_drain");

        // Noise then zero-length packet
        send_byte(8'h00, 1);
        send_byte(8'hFF, 0);
        pl = {};
        send_packet(pl, 0, -1, 2);
        drain("zero_drain");
        chk("zero_words", 64'(words_written), 0);

        // Randomized packets with leading noise
        for (int p = 0; p < 8; p++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                nb = 8'($urandom);
                if (nb == 8'hA5) nb = 8'h5A;
                send_byte(nb, 0);
            end
            n  = $urandom_range(0, 4);
            rp = {};
            for (int unsigned b = 0; b < 8 * n; b++) rp.push_back(8'($urandom));
            send_packet(rp, n, ($urandom_range(0, 3) == 0) ? -2 : -1, 3);
            drain("rand_drain");
        end

        // Abort by dropping enable after four payload bytes: no pulses, code kept
        send_packet(pl, 0, -1, 0);
        drain("pre_abort_drain");
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i), 0);
        enable = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("abort_busy", 64'(busy), 0);
        chk("abort_error_code", 64'(error_code), 0);
        enable = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        chk("abort_quiet", 64'(sb.size()), 0);

        // Reset in the middle of a new packet, then a good packet from addr 0
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        rstN = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b1;
        check_reset_outputs();
        pl = {};
        for (int i = 0; i < 16; i++) pl.push_back(8'($urandom));
        send_packet(pl, 2, -1, 2);
        drain("post_reset_drain");
        chk("post_reset_words", 64'(words_written), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got no finish, required finish");
        $fatal(1, "time limit");
    end

endmodule
